// File: rtl/pc_gen.sv
// Program-counter generator for the instruction-fetch stage.
// Sequential fetch with flush/branch redirects; a branch seen while IF is stalled is buffered until release.
module pc_gen #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                INST_BYTES   = 4,
  parameter int                STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               pend_valid_o
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_FLUSH,
    SEL_BRANCH,
    SEL_PEND,
    SEL_SEQ
  } pc_sel_e;

  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;

  logic              stall_if;
  logic [ADDR_W-1:0] flush_target;
  logic [ADDR_W-1:0] branch_target;
  pc_sel_e           pc_sel;

  // Only the IF stall bit matters; the rest of the vector is folded away on purpose.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign stall_if      = stall[0];
  assign flush_target  = new_pc & ALIGN_MASK;
  assign branch_target = branch_target_address_i & ALIGN_MASK;

  always_comb begin
    pc_sel = SEL_HOLD;
    if (ce_q) begin
      if (flush)              pc_sel = SEL_FLUSH;
      else if (stall_if)      pc_sel = SEL_HOLD;
      else if (branch_flag_i) pc_sel = SEL_BRANCH;
      else if (pend_valid_q)  pc_sel = SEL_PEND;
      else                    pc_sel = SEL_SEQ;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    ce_d          = 1'b1;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    unique case (pc_sel)
      SEL_FLUSH: begin
        pc_d         = flush_target;
        pend_valid_d = 1'b0;
      end
      SEL_BRANCH: begin
        pc_d         = branch_target;
        pend_valid_d = 1'b0;
      end
      SEL_PEND: begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
      end
      SEL_SEQ: begin
        pc_d = pc_q + STEP;
      end
      SEL_HOLD: begin
        // Stalled with a live branch: capture it, newest branch wins.
        if (ce_q && branch_flag_i) begin
          pend_valid_d  = 1'b1;
          pend_target_d = branch_target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      ce_q          <= 1'b0;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      ce_q          <= ce_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc           = pc_q;
  assign ce           = ce_q;
  assign pend_valid_o = pend_valid_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the first (instruction-fetch) stage of the five-stage pipeline. It produces the fetch address `pc` and the instruction-memory enable `ce`, and advances sequentially by one instruction per cycle. It accepts branch redirects from ID and flush redirects from CTRL. Unlike the single-cycle first-generation PC register, it holds a pending branch that arrives while IF is stalled, so the redirect is never lost, and its width, reset vector and fetch step are configurable.

## Interface
Parameters:
- `ADDR_W`, 32, width of `pc` and of all redirect targets.
- `RESET_VECTOR`, 32'h00000000, value of `pc` during and immediately after reset; must be `INST_BYTES`-aligned.
- `INST_BYTES`, 4, byte increment per sequential fetch; power of two, 1..8.
- `STALL_W`, 6, width of the stall vector from CTRL.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  `STALL_W`  per-stage stall from CTRL; only `stall[0]` (IF) is used; 1 = stop.
- `flush`  in  1  exception/flush redirect from CTRL; overrides stall.
- `new_pc`  in  `ADDR_W`  flush target, valid when `flush`=1.
- `branch_flag_i`  in  1  ID reports a taken branch/jump.
- `branch_target_address_i`  in  `ADDR_W`  branch target, valid when `branch_flag_i`=1.
- `pc`  out  `ADDR_W`  current fetch address (registered).
- `ce`  out  1  instruction-memory enable (registered); 1 = enabled.
- `pend_valid_o`  out  1  a branch redirect is buffered awaiting stall release.

## Operation
- State consists of the `ce`, `pc`, `pend_valid` and `pend_target` registers.
- Targets are aligned on capture: the low log2(`INST_BYTES`) bits of `new_pc` and `branch_target_address_i` are forced to 0.
- When `rst`=1, the block loads `ce`=0, `pc`=`RESET_VECTOR`, `pend_valid`=0 and `pend_target`=0.
- When `rst`=0, the block sets `ce`=1 on every edge.
- While `ce`=0 (the first cycle after reset release), `pc` holds `RESET_VECTOR`. The block ignores `flush`, `branch_flag_i` and `stall` in this state.
- While `ce`=1, the next `pc` is chosen in strict priority order:
  1. `flush`=1: `pc`=`new_pc`, `pend_valid`=0. This applies regardless of `stall[0]` or `branch_flag_i`.
  2. `stall[0]`=0 and `branch_flag_i`=1: `pc`=`branch_target_address_i`, `pend_valid`=0. A live branch supersedes any buffered one.
  3. `stall[0]`=0 and `pend_valid`=1: `pc`=`pend_target`, `pend_valid`=0.
  4. `stall[0]`=0: `pc`=`pc`+`INST_BYTES`, modulo 2^`ADDR_W`. The address wraps from the top to 0 with no flag.
  5. `stall[0]`=1: `pc` holds. If `branch_flag_i`=1, the block sets `pend_valid`=1 and `pend_target`=`branch_target_address_i`. A later branch during the same stall overwrites the earlier one (last wins).
- `pend_valid_o` equals the `pend_valid` register.

## Timing
- Every output is registered, and every input takes effect at the next rising edge, giving a redirect latency of 1 cycle.
- Reset values:
  - `ce`=0
  - `pc`=`RESET_VECTOR`
  - `pend_valid_o`=0
- Reset release sequence, with edge 0 being the first edge with `rst`=0:
  - After edge 0: `ce`=1, `pc`=`RESET_VECTOR`.
  - After edge 1: `pc`=`RESET_VECTOR`+`INST_BYTES`, provided there is no stall or redirect.
- A buffered branch is applied on the first edge where `stall[0]`=0, unless `flush` or a live branch takes priority on that edge.
- Asserting `rst` mid-stall or mid-pending discards the buffered branch at that edge. `rst` takes priority over `flush`.
- `stall[STALL_W-1:1]` has no effect.

## Test plan
- Reset sequence with `RESET_VECTOR`=32'hBFC00000: hold `rst`=1 for 3 cycles, then release. Required: `ce`=0 and `pc`=BFC00000 during reset; one cycle with `ce`=1 and `pc`=BFC00000; then BFC00004, BFC00008.
- Wrap-around with `ADDR_W`=32: flush to FFFFFFF8, then run 3 unstalled cycles. Required: `pc` = FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Unstalled branch: with `pc`=00000010, drive `branch_flag_i`=1 and target 00000104 for one cycle. Required: `pc`=00000104 next cycle, 00000108 the cycle after. With `INST_BYTES`=4, target 00000107 yields 00000104.
- Branch during stall: drive `stall[0]`=1 for 3 cycles with `pc`=00000020, and pulse the branch to 00000200 in the first stall cycle, then 00000300 in the second. Required: `pc` holds 00000020 and `pend_valid_o`=1. After release, `pc`=00000300, `pend_valid_o`=0, then 00000304.
- Flush priority: with `stall[0]`=1 and a pending branch, assert `flush` with `new_pc`=00000380 together with `branch_flag_i`=1. Required: `pc`=00000380 next cycle, `pend_valid_o`=0, and no later jump to the pending target.
- Reset mid-pending: create a pending branch, then assert `rst` for 1 cycle. Required: `pc`=`RESET_VECTOR`, `pend_valid_o`=0, and the normal sequence afterwards with no stale redirect.
